// File: rtl/stage_w.sv
// stage_w: writeback stage of the CPU pipeline.
//
// Accepts one retiring instruction per cycle from the memory stage, aligns and
// sign/zero-extends load data from the 8-byte-aligned data-bus word, and issues
// a registered register-file write (rf_*), which also serves as the forwarding
// source for earlier stages. A misaligned load raises a load-address-misaligned
// trap (cause 4) and stalls W until trap_ack_i.
//
// Optional build macro: STAGE_W_INSTRET_EN adds instret_o, a 64-bit retire
// counter that counts every accepted instruction that does not trap.
//
// Ports:
//   clk_i, reset_i (async, active-low)
//   m_valid_i / w_ready_o         : handshake with M
//   m_rd_i, m_we_i, m_load_i      : destination, write enable, load flag
//   m_size_i, m_unsigned_i        : load size (0..3 = B/H/W/D), zero-extend
//   m_addr_lo_i                   : load address bits [2:0]
//   m_result_i, m_dat_i           : non-load result, raw bus read word
//   rf_we_o, rf_rd_o, rf_dat_o    : registered register-file write
//   trap_o, trap_cause_o          : pending misaligned-load trap
//   trap_ack_i                    : trap handler accepts the trap
//   instret_o (optional)          : retire counter
module stage_w #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            m_valid_i,
  output logic            w_ready_o,
  input  logic [4:0]      m_rd_i,
  input  logic            m_we_i,
  input  logic            m_load_i,
  input  logic [1:0]      m_size_i,
  input  logic            m_unsigned_i,
  input  logic [2:0]      m_addr_lo_i,
  input  logic [XLEN-1:0] m_result_i,
  input  logic [XLEN-1:0] m_dat_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_dat_o,
  output logic            trap_o,
  output logic [3:0]      trap_cause_o,
  input  logic            trap_ack_i
`ifdef STAGE_W_INSTRET_EN
  ,
  output logic [63:0]     instret_o
`endif
);

  typedef enum logic [0:0] {StRun, StTrap} state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic            r_we;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_dat;

  logic            w_accept;
  logic            w_misaligned;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_load_dat;
  logic [XLEN-1:0] w_wr_dat;

  assign w_ready_o = (r_state == StRun);
  assign w_accept  = m_valid_i & w_ready_o;

  // Address must be a multiple of the access size; byte loads always align.
  always_comb begin
    w_misaligned = 1'b0;
    if (m_load_i) begin
      unique case (m_size_i)
        2'd0: w_misaligned = 1'b0;
        2'd1: w_misaligned = m_addr_lo_i[0];
        2'd2: w_misaligned = |m_addr_lo_i[1:0];
        2'd3: w_misaligned = |m_addr_lo_i;
        default: w_misaligned = 1'b0;
      endcase
    end
  end

  // Bring the addressed byte lane down to bit 0, then extend by size.
  assign w_shift = m_dat_i >> {m_addr_lo_i, 3'b000};

  always_comb begin
    w_load_dat = w_shift;
    unique case (m_size_i)
      2'd0: w_load_dat = m_unsigned_i ? {{(XLEN-8){1'b0}}, w_shift[7:0]}
                                      : {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      2'd1: w_load_dat = m_unsigned_i ? {{(XLEN-16){1'b0}}, w_shift[15:0]}
                                      : {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      2'd2: w_load_dat = m_unsigned_i ? {{(XLEN-32){1'b0}}, w_shift[31:0]}
                                      : {{(XLEN-32){w_shift[31]}}, w_shift[31:0]};
      2'd3: w_load_dat = w_shift;
      default: w_load_dat = w_shift;
    endcase
  end

  assign w_wr_dat = m_load_i ? w_load_dat : m_result_i;

  // Next-state logic; trap_ack_i only matters while a trap is pending.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (w_accept && w_misaligned) w_state_next = StTrap;
      StTrap:  if (trap_ack_i) w_state_next = StRun;
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= StRun;
    end else begin
      r_state <= w_state_next;
    end
  end

  // rf_rd/rf_dat track every accept (even a trapping one); rf_we is a one-cycle pulse.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_we  <= 1'b0;
      r_rd  <= 5'd0;
      r_dat <= '0;
    end else begin
      r_we <= w_accept & m_we_i & (m_rd_i != 5'd0) & ~w_misaligned;
      if (w_accept) begin
        r_rd  <= m_rd_i;
        r_dat <= w_wr_dat;
      end
    end
  end

  assign rf_we_o      = r_we;
  assign rf_rd_o      = r_rd;
  assign rf_dat_o     = r_dat;
  assign trap_o       = (r_state == StTrap);
  assign trap_cause_o = (r_state == StTrap) ? 4'd4 : 4'd0;

`ifdef STAGE_W_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_instret <= 64'd0;
    end else if (w_accept && !w_misaligned) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_stage_w.sv
module tb_stage_w;

  logic        clk_i;
  logic        reset_i;
  logic        m_valid_i;
  logic        w_ready_o;
  logic [4:0]  m_rd_i;
  logic        m_we_i;
  logic        m_load_i;
  logic [1:0]  m_size_i;
  logic        m_unsigned_i;
  logic [2:0]  m_addr_lo_i;
  logic [63:0] m_result_i;
  logic [63:0] m_dat_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [63:0] rf_dat_o;
  logic        trap_o;
  logic [3:0]  trap_cause_o;
  logic        trap_ack_i;
`ifdef STAGE_W_INSTRET_EN
  logic [63:0] instret_o;
`endif

  int total;
  int bad;

  stage_w #(.XLEN(64)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .m_valid_i    (m_valid_i),
    .w_ready_o    (w_ready_o),
    .m_rd_i       (m_rd_i),
    .m_we_i       (m_we_i),
    .m_load_i     (m_load_i),
    .m_size_i     (m_size_i),
    .m_unsigned_i (m_unsigned_i),
    .m_addr_lo_i  (m_addr_lo_i),
    .m_result_i   (m_result_i),
    .m_dat_i      (m_dat_i),
    .rf_we_o      (rf_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_dat_o     (rf_dat_o),
    .trap_o       (trap_o),
    .trap_cause_o (trap_cause_o),
    .trap_ack_i   (trap_ack_i)
`ifdef STAGE_W_INSTRET_EN
    ,
    .instret_o    (instret_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; m_valid_i = 1'b1; m_we_i = 1'b1; m_rd_i = 5'd5; m_load_i = 1'b0;
    m_size_i = 2'd0; m_unsigned_i = 1'b0; m_addr_lo_i = 3'd0; m_result_i = 64'hABCD;
    m_dat_i = 64'd0; trap_ack_i = 1'b0;
    step(); step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
    total++; if (trap_o !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b exp=0", trap_o); end
    total++; if (w_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", w_ready_o); end
    total++; if (rf_rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0d exp=0", rf_rd_o); end
    total++; if (rf_dat_o !== 64'd0) begin bad++; $display("FAIL reset_dat got=%h exp=0", rf_dat_o); end
    total++; if (trap_cause_o !== 4'd0) begin bad++; $display("FAIL reset_cause got=%0d exp=0", trap_cause_o); end
`ifdef STAGE_W_INSTRET_EN
    total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret_o); end
`endif
    reset_i = 1'b1;
    step();
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL post_reset_we got=%b exp=1", rf_we_o); end
    total++; if (rf_rd_o !== 5'd5) begin bad++; $display("FAIL post_reset_rd got=%0d exp=5", rf_rd_o); end
    total++; if (rf_dat_o !== 64'hABCD) begin bad++; $display("FAIL post_reset_dat got=%h exp=abcd", rf_dat_o); end
    m_valid_i = 1'b0;
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", rf_we_o); end
  endtask

  task automatic test_alu_write();
    m_valid_i = 1'b1; m_we_i = 1'b1; m_load_i = 1'b0; m_rd_i = 5'd3; m_result_i = 64'h1234;
    step();
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL alu_we got=%b exp=1", rf_we_o); end
    total++; if (rf_rd_o !== 5'd3) begin bad++; $display("FAIL alu_rd got=%0d exp=3", rf_rd_o); end
    total++; if (rf_dat_o !== 64'h1234) begin bad++; $display("FAIL alu_dat got=%h exp=1234", rf_dat_o); end
    m_rd_i = 5'd0; m_result_i = 64'h5678;
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", rf_we_o); end
    total++; if (rf_dat_o !== 64'h5678) begin bad++; $display("FAIL x0_dat got=%h exp=5678", rf_dat_o); end
    m_rd_i = 5'd4; m_we_i = 1'b0;
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL nowe_we got=%b exp=0", rf_we_o); end
    m_valid_i = 1'b0; m_we_i = 1'b1;
    step();
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
    logic        uns [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  adr [6] = '{3'd1, 3'd1, 3'd6, 3'd4, 3'd4, 3'd0};
    logic [63:0] exp [6] = '{64'hFFFFFFFFFFFFFFEE, 64'h00000000000000EE, 64'hFFFFFFFFFFFF8899,
                             64'hFFFFFFFF8899AABB, 64'h000000008899AABB, 64'h8899AABBCCDDEEFF};
    m_dat_i = 64'h8899AABBCCDDEEFF; m_result_i = 64'h0; m_we_i = 1'b1; m_load_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      m_valid_i = 1'b1; m_rd_i = 5'(10 + i);
      m_size_i = sz[i]; m_unsigned_i = uns[i]; m_addr_lo_i = adr[i];
      step();
      total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL load%0d_we got=%b exp=1", i, rf_we_o); end
      total++; if (rf_rd_o !== 5'(10 + i)) begin bad++; $display("FAIL load%0d_rd got=%0d exp=%0d", i, rf_rd_o, 10 + i); end
      total++; if (rf_dat_o !== exp[i]) begin bad++; $display("FAIL load%0d_dat got=%h exp=%h", i, rf_dat_o, exp[i]); end
    end
    m_valid_i = 1'b0; m_load_i = 1'b0; m_unsigned_i = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    m_valid_i = 1'b1; m_we_i = 1'b1; m_load_i = 1'b1; m_size_i = 2'd2; m_addr_lo_i = 3'd2;
    m_rd_i = 5'd7;
    step();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL mis_we got=%b exp=0", rf_we_o); end
    total++; if (trap_o !== 1'b1) begin bad++; $display("FAIL mis_trap got=%b exp=1", trap_o); end
    total++; if (trap_cause_o !== 4'd4) begin bad++; $display("FAIL mis_cause got=%0d exp=4", trap_cause_o); end
    total++; if (w_ready_o !== 1'b0) begin bad++; $display("FAIL mis_ready got=%b exp=0", w_ready_o); end
    // Valid aligned write held while trapped must be ignored.
    m_load_i = 1'b0; m_addr_lo_i = 3'd0; m_rd_i = 5'd9; m_result_i = 64'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL hold%0d_we got=%b exp=0", i, rf_we_o); end
      total++; if (trap_o !== 1'b1) begin bad++; $display("FAIL hold%0d_trap got=%b exp=1", i, trap_o); end
      total++; if (rf_rd_o !== 5'd7) begin bad++; $display("FAIL hold%0d_rd got=%0d exp=7", i, rf_rd_o); end
    end
    trap_ack_i = 1'b1;
    step();
    trap_ack_i = 1'b0;
    total++; if (trap_o !== 1'b0) begin bad++; $display("FAIL ack_trap got=%b exp=0", trap_o); end
    total++; if (trap_cause_o !== 4'd0) begin bad++; $display("FAIL ack_cause got=%0d exp=0", trap_cause_o); end
    total++; if (w_ready_o !== 1'b1) begin bad++; $display("FAIL ack_ready got=%b exp=1", w_ready_o); end
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL ack_we got=%b exp=0", rf_we_o); end
    // The held instruction is accepted now that W is back in RUN.
    step();
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL resume_we got=%b exp=1", rf_we_o); end
    total++; if (rf_rd_o !== 5'd9) begin bad++; $display("FAIL resume_rd got=%0d exp=9", rf_rd_o); end
    m_valid_i = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_trap();
    m_valid_i = 1'b1; m_we_i = 1'b1; m_load_i = 1'b1; m_size_i = 2'd3; m_addr_lo_i = 3'd3;
    m_rd_i = 5'd12;
    step();
    m_valid_i = 1'b0;
    total++; if (trap_o !== 1'b1) begin bad++; $display("FAIL rmt_trap got=%b exp=1", trap_o); end
    #2 reset_i = 1'b0;
    #1;
    total++; if (trap_o !== 1'b0) begin bad++; $display("FAIL rmt_async_trap got=%b exp=0", trap_o); end
    total++; if (w_ready_o !== 1'b1) begin bad++; $display("FAIL rmt_ready got=%b exp=1", w_ready_o); end
    total++; if (rf_rd_o !== 5'd0) begin bad++; $display("FAIL rmt_rd got=%0d exp=0", rf_rd_o); end
    m_load_i = 1'b0; m_addr_lo_i = 3'd0;
    step();
    reset_i = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    reset_i = 1'b0; m_valid_i = 1'b0;
    #1 reset_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m_valid_i = 1'b1; m_we_i = 1'b1; m_rd_i = 5'(i + 1); m_result_i = 64'(i);
      m_load_i = (i == 3); m_size_i = 2'd1; m_addr_lo_i = (i == 3) ? 3'd1 : 3'd0;
      step();
      if (rf_we_o) pulses++;
      if (i == 3) begin
        total++; if (trap_o !== 1'b1) begin bad++; $display("FAIL b2b_trap got=%b exp=1", trap_o); end
        m_load_i = 1'b0; m_addr_lo_i = 3'd0; m_rd_i = 5'd20;
        step();
        if (rf_we_o) pulses++;
        trap_ack_i = 1'b1;
        step();
        if (rf_we_o) pulses++;
        trap_ack_i = 1'b0;
        total++; if (w_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", w_ready_o); end
      end
    end
    total++; if (rf_rd_o !== 5'd10) begin bad++; $display("FAIL b2b_last_rd got=%0d exp=10", rf_rd_o); end
    m_valid_i = 1'b0;
    step();
    if (rf_we_o) pulses++;
    total++; if (pulses !== 9) begin bad++; $display("FAIL b2b_pulses got=%0d exp=9", pulses); end
`ifdef STAGE_W_INSTRET_EN
    total++; if (instret_o !== 64'd9) begin bad++; $display("FAIL b2b_instret got=%0d exp=9", instret_o); end
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu_write();
    test_loads();
    test_misaligned();
    test_reset_mid_trap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_w.md
Name: stage_w

Overview:
Writeback stage of the CPU pipeline, directly downstream of the memory stage. It accepts one retiring instruction per cycle from M, aligns and sign- or zero-extends load data returned on the data bus, and issues a registered register-file write. It also exposes the written value for forwarding to earlier stages. Misaligned loads are converted into a trap request that holds W until the trap is acknowledged.

Parameters:
XLEN, 64, datapath width in bits; 64 is the only supported value.

Ports:
clk_i  in  1  pipeline clock.
reset_i  in  1  asynchronous, active-low reset.
m_valid_i  in  1  M presents a retiring instruction; for loads, only asserted once read data is present.
w_ready_o  out  1  W can accept from M this cycle.
m_rd_i  in  5  destination register index.
m_we_i  in  1  instruction writes rd.
m_load_i  in  1  instruction is a load; write data comes from m_dat_i.
m_size_i  in  2  load size: 0=byte, 1=half, 2=word, 3=dword.
m_unsigned_i  in  1  zero-extend the load (LBU/LHU/LWU).
m_addr_lo_i  in  3  low bits of the load effective address.
m_result_i  in  XLEN  ALU/CSR result for non-loads.
m_dat_i  in  XLEN  raw data-bus read word, naturally aligned to 8 bytes.
rf_we_o  out  1  register-file write strobe.
rf_rd_o  out  5  register-file write index.
rf_dat_o  out  XLEN  register-file write data.
trap_o  out  1  load-address-misaligned trap pending.
trap_cause_o  out  4  trap cause; 4 whenever trap_o=1, else 0.
trap_ack_i  in  1  trap handler accepts the trap.

Behaviour:
- Reset (reset_i=0, asynchronous): state=RUN. rf_we_o=0, rf_rd_o=0, rf_dat_o=0, trap_o=0, trap_cause_o=0. The retire counter (if compiled in) is 0. Reset mid-trap abandons the trap.
- Accept: a transfer occurs when m_valid_i=1 and w_ready_o=1. w_ready_o=1 exactly when state=RUN.
- Outputs are registered. rf_* reflect an accepted instruction on the cycle after acceptance and are valid for exactly one cycle.
- rf_we_o is set to 1 on the cycle after acceptance if and only if all of the following hold:
  - m_we_i=1
  - m_rd_i is not 0
  - the instruction is not a misaligned load.
  Otherwise rf_we_o=0.
- rf_rd_o and rf_dat_o update on every accept. They hold their last value when no transfer occurs.
- Forwarding uses rf_we_o, rf_rd_o and rf_dat_o directly; there are no separate forwarding ports.
- Non-load write data: rf_dat_o = m_result_i.
- Load alignment:
  - Byte lane offset = m_addr_lo_i (byte 0 is bits 7:0).
  - Extract 8, 16, 32 or 64 bits starting at lane m_addr_lo_i.
  - Sign-extend to XLEN, or zero-extend when m_unsigned_i=1.
  - For dword loads, m_unsigned_i is ignored.
- Misalignment: a load is misaligned when m_addr_lo_i is not a multiple of 2^m_size_i, i.e.:
  - half: bit 0 set
  - word: bits 1:0 nonzero
  - dword: any bit set.
  Byte loads are never misaligned.
- State machine:
  - RUN: accepting a misaligned load moves to TRAP and sets trap_o=1 and trap_cause_o=4 on the next cycle. trap_ack_i is ignored in RUN.
  - TRAP: w_ready_o=0 and m_valid_i is ignored. trap_o stays at 1 until a cycle with trap_ack_i=1. On the next edge: state=RUN, trap_o=0, trap_cause_o=0. W can accept again on that following cycle.
- Back-to-back: one accept per cycle in RUN, with no bubbles required. A write to rd followed by a load to the same rd yields two consecutive write cycles.

Optional Feature:
STAGE_W_INSTRET_EN
- Defined:
  - Adds output port instret_o (64 bits), a retire counter.
  - The counter increments by 1 on each accept that does not trap, whether or not the instruction writes a register.
  - Wraps from 2^64-1 to 0.
  - Resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with m_valid_i=1 held, m_we_i=1, m_rd_i=5 -> rf_we_o=0, trap_o=0, w_ready_o=1 while reset is asserted; after release, first edge -> rf_we_o=1, rf_rd_o=5.
- Non-load write, m_rd_i=3, m_result_i=64'h1234 -> next cycle rf_we_o=1, rf_rd_o=3, rf_dat_o=64'h1234. Repeat with m_rd_i=0 -> rf_we_o=0.
- Loads with m_dat_i=64'h8899AABBCCDDEEFF:
  - LB, addr_lo=1 -> FFFFFFFFFFFFFFEE
  - LBU, addr_lo=1 -> EE
  - LH, addr_lo=6 -> FFFFFFFFFFFF8899
  - LW, addr_lo=4 -> FFFFFFFF8899AABB
  - LWU, addr_lo=4 -> 8899AABB
  - LD, addr_lo=0 -> full word.
- Misaligned LW, addr_lo=2, rd=7 -> rf_we_o=0; trap_o=1, trap_cause_o=4, w_ready_o=0. Hold trap_ack_i=0 for 3 cycles with m_valid_i=1 -> no writes. Pulse trap_ack_i -> trap_o=0 and w_ready_o=1 on the following cycle.
- Ten consecutive accepts, the 4th a misaligned LH (ack given 2 cycles later) -> instret_o=9 when STAGE_W_INSTRET_EN is defined; exactly 9 rf_we_o pulses if all rd are nonzero.
